// File: rtl/uart_stim_tx.sv
// Byte-stream to UART 8N1 serializer with an internal byte FIFO.
// Bytes queue through valid/ready and leave LSB-first at CLKS_PER_BIT clocks per bit.
module uart_stim_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic          r_stop_cnt, w_stop_cnt_nxt;
  logic [7:0]    r_shreg, w_shreg_nxt;
  logic          r_tx, w_tx_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop, w_nonempty, w_baud_end;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
  assign in_ready   = (r_count != FULL_LVL);
  assign w_push     = in_valid && in_ready;
  assign w_nonempty = (r_count != '0);
  assign w_baud_end = (r_baud == BAUD_LAST);

  assign tx    = r_tx;
  assign busy  = (r_state != S_IDLE);
  assign level = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = w_baud_end ? '0 : r_baud + BAUD_ONE;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_cnt_nxt = r_stop_cnt;
    w_shreg_nxt    = r_shreg;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = r_mem[r_rd_ptr];
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_shreg_nxt   = {1'b0, r_shreg[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt    = S_STOP;
            w_stop_cnt_nxt = 1'b0;
          end
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (STOP_BITS == 2 && !r_stop_cnt) begin
            w_stop_cnt_nxt = 1'b1;
          end else if (w_nonempty) begin
            // Chain straight into the next start bit: no idle gap between queued frames.
            w_pop       = 1'b1;
            w_shreg_nxt = r_mem[r_rd_ptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: two instances (4 clk/bit 1 stop, 8 clk/bit 2 stops) against
// a frame-rule model and a mid-bit sampling UART decoder.
module tb_uart_stim_tx;
  localparam int CPB_A = 4, SB_A = 1, CPB_B = 8, SB_B = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic vld_a, vld_b, rdy_a, rdy_b, tx_a, tx_b, bsy_a, bsy_b;
  logic [7:0] dat_a, dat_b;
  logic [4:0] lvl_a, lvl_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q [2][$];
  int rx_q  [2][$];
  int st_q  [2][$];
  bit ok_q  [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_stim_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_a), .in_data(dat_a), .in_ready(rdy_a),
    .tx(tx_a), .busy(bsy_a), .level(lvl_a));
  uart_stim_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_b), .in_data(dat_b), .in_ready(rdy_b),
    .tx(tx_b), .busy(bsy_b), .level(lvl_b));

  function automatic int cpb(int d);  return d ? CPB_B : CPB_A; endfunction
  function automatic int sb(int d);   return d ? SB_B : SB_A; endfunction
  function automatic int flen(int d); return (9 + sb(d)) * cpb(d); endfunction
  function automatic logic tx_of(int d);  return d ? tx_b : tx_a; endfunction
  function automatic logic rdy_of(int d); return d ? rdy_b : rdy_a; endfunction

  // Reference decoder: samples each bit at its middle, records byte, start cycle, stop validity.
  int dec_act[2], dec_cnt[2], dec_st[2], dec_j;
  logic [7:0] dec_sh[2];
  bit dec_ok[2];
  logic dec_prev[2], dec_t;
  initial begin
    for (int d = 0; d < 2; d++) begin dec_act[d] = 0; dec_prev[d] = 1'b1; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        dec_t = tx_of(d);
        if (!rst_n) dec_act[d] = 0;
        else if (dec_act[d] == 0) begin
          if (dec_prev[d] && !dec_t) begin
            dec_act[d] = 1; dec_cnt[d] = 0; dec_st[d] = cyc; dec_ok[d] = 1'b1; dec_sh[d] = 8'h00;
          end
        end else begin
          dec_cnt[d]++;
          if (dec_cnt[d] % cpb(d) == cpb(d) / 2) begin
            dec_j = dec_cnt[d] / cpb(d);
            if (dec_j == 0) begin if (dec_t) dec_ok[d] = 1'b0; end
            else if (dec_j <= 8) dec_sh[d][dec_j-1] = dec_t;
            else if (!dec_t) dec_ok[d] = 1'b0;
            if (dec_j == 8 + sb(d)) begin
              rx_q[d].push_back(int'(dec_sh[d])); st_q[d].push_back(dec_st[d]);
              ok_q[d].push_back(dec_ok[d]); dec_act[d] = 0;
            end
          end
        end
        dec_prev[d] = dec_t;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wait_edge(input int n); while (cyc < n) tick(); endtask
  task automatic clear(input int d);
    exp_q[d].delete(); rx_q[d].delete(); st_q[d].delete(); ok_q[d].delete();
  endtask
  task automatic set_in(input int d, input logic v, input logic [7:0] b);
    if (d == 0) begin vld_a = v; dat_a = b; end else begin vld_b = v; dat_b = b; end
  endtask
  // Offers one byte; returns the accepting edge number or -1 after budget cycles.
  task automatic push(input int d, input logic [7:0] b, input int budget, output int acc);
    logic r;
    acc = -1;
    set_in(d, 1'b1, b);
    for (int k = 0; k < budget && acc < 0; k++) begin
      @(negedge clk); r = rdy_of(d);
      tick();
      if (r) begin acc = cyc; exp_q[d].push_back(int'(b)); end
    end
    set_in(d, 1'b0, 8'h00);
  endtask
  task automatic wait_rx(input int d, input int n, input int budget);
    for (int k = 0; k < budget && rx_q[d].size() < n; k++) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (tx_a !== 1'b1 || tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b/%b, expected 1/1", tx_a, tx_b); end
    checks++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b, expected 1/1", rdy_a, rdy_b); end
    checks++; if (bsy_a !== 1'b0 || bsy_b !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b, expected 0/0", bsy_a, bsy_b); end
    checks++; if (lvl_a !== 5'd0 || lvl_b !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d/%0d, expected 0/0", lvl_a, lvl_b); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_single_byte();
    logic [7:0] b[2];
    int p, k, bitn;
    logic etx, ebsy;
    b[0] = 8'h55; b[1] = 8'($urandom_range(0, 255));
    for (int t = 0; t < 2; t++) begin
      clear(0);
      push(0, b[t], 4, p);
      checks++; if (p < 0) begin errors++; $display("FAIL single_accept: byte %h not accepted", b[t]); end
      @(negedge clk);
      checks++; if (lvl_a !== 5'd1) begin errors++; $display("FAIL single_level: got %0d, expected 1", lvl_a); end
      for (int e = p + 1; e <= p + flen(0) + 4; e++) begin
        @(negedge clk);
        k = e - (p + 1); bitn = k / CPB_A;
        etx  = (k >= flen(0) || bitn > 8) ? 1'b1 : (bitn == 0) ? 1'b0 : b[t][bitn-1];
        ebsy = (k < flen(0));
        checks++;
        if (tx_a !== etx || bsy_a !== ebsy) begin
          errors++; $display("FAIL single_wave edge+%0d: tx=%b busy=%b, expected tx=%b busy=%b", k + 1, tx_a, bsy_a, etx, ebsy);
        end
      end
      tick(); wait_rx(0, 1, 50);
      checks++;
      if (rx_q[0].size() != 1 || rx_q[0][0] != int'(b[t]) || !ok_q[0][0]) begin
        errors++; $display("FAIL single_decode: got %0d bytes first %h, expected %h", rx_q[0].size(), rx_q[0].size() ? rx_q[0][0] : -1, b[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0, p1, pa, n;
    clear(0);
    push(0, 8'h00, 4, p0);
    push(0, 8'hFF, 4, p1);
    checks++; if (p1 != p0 + 1) begin errors++; $display("FAIL b2b_push: second accepted at %0d, expected %0d", p1, p0 + 1); end
    n = $urandom_range(3, 6);
    for (int i = 0; i < n; i++) push(0, 8'($urandom_range(0, 255)), 4, pa);
    wait_rx(0, n + 2, (n + 3) * flen(0) + 100);
    checks++; if (st_q[0].size() > 0 && st_q[0][0] != p0 + 1) begin errors++; $display("FAIL b2b_first_start: got %0d, expected %0d", st_q[0][0], p0 + 1); end
    for (int i = 0; i + 1 < st_q[0].size(); i++) begin
      checks++;
      if (st_q[0][i+1] - st_q[0][i] != flen(0)) begin errors++; $display("FAIL b2b_spacing %0d: got %0d, expected %0d", i, st_q[0][i+1] - st_q[0][i], flen(0)); end
    end
    for (int i = 0; i < exp_q[0].size(); i++) begin
      checks++;
      if (i >= rx_q[0].size() || rx_q[0][i] != exp_q[0][i] || !ok_q[0][i]) begin
        errors++; $display("FAIL b2b_byte %0d: got %h, expected %h", i, i < rx_q[0].size() ? rx_q[0][i] : -1, exp_q[0][i]);
      end
    end
  endtask

  task automatic test_full_fifo();
    int p, acc[17];
    clear(0);
    push(0, 8'($urandom_range(0, 255)), 4, p);
    for (int i = 0; i < 16; i++) push(0, 8'($urandom_range(0, 255)), 4, acc[i]);
    @(negedge clk);
    checks++; if (lvl_a !== 5'd16 || rdy_a !== 1'b0) begin errors++; $display("FAIL full_state: level=%0d ready=%b, expected 16/0", lvl_a, rdy_a); end
    tick();
    push(0, 8'($urandom_range(0, 255)), 100, acc[16]);
    checks++; if (acc[15] != p + 16) begin errors++; $display("FAIL full_fill: 16th accepted at %0d, expected %0d", acc[15], p + 16); end
    checks++; if (acc[16] != p + 2 + flen(0)) begin errors++; $display("FAIL full_17th: accepted at %0d, expected %0d", acc[16], p + 2 + flen(0)); end
    wait_rx(0, 18, 18 * flen(0) + 200);
    checks++; if (rx_q[0].size() != 18) begin errors++; $display("FAIL full_count: got %0d bytes, expected 18", rx_q[0].size()); end
    for (int i = 0; i < exp_q[0].size(); i++) begin
      checks++;
      if (i >= rx_q[0].size() || rx_q[0][i] != exp_q[0][i] || !ok_q[0][i]) begin
        errors++; $display("FAIL full_byte %0d: got %h, expected %h", i, i < rx_q[0].size() ? rx_q[0][i] : -1, exp_q[0][i]);
      end
    end
  endtask

  task automatic test_two_stop();
    int p, fall, bfall, hi;
    clear(1);
    push(1, 8'hA3, 4, p);
    fall = -1; bfall = -1; hi = 0;
    for (int e = p + 1; e <= p + flen(1) + 4; e++) begin
      @(negedge clk);
      if (fall < 0 && tx_b === 1'b0) fall = cyc;
      if (fall >= 0 && bfall < 0 && bsy_b === 1'b0) bfall = cyc;
      if (fall >= 0 && cyc >= fall + 9 * CPB_B && cyc < fall + flen(1) && tx_b === 1'b1) hi++;
    end
    tick();
    checks++; if (fall != p + 1) begin errors++; $display("FAIL stop2_start: got %0d, expected %0d", fall, p + 1); end
    checks++; if (bfall - fall != 88) begin errors++; $display("FAIL stop2_frame_len: got %0d, expected 88", bfall - fall); end
    checks++; if (hi != SB_B * CPB_B) begin errors++; $display("FAIL stop2_high: got %0d, expected %0d", hi, SB_B * CPB_B); end
    push(1, 8'($urandom_range(0, 255)), 4, p);
    wait_rx(1, 2, 2 * flen(1) + 50);
    for (int i = 0; i < exp_q[1].size(); i++) begin
      checks++;
      if (i >= rx_q[1].size() || rx_q[1][i] != exp_q[1][i] || !ok_q[1][i]) begin
        errors++; $display("FAIL stop2_byte %0d: got %h, expected %h", i, i < rx_q[1].size() ? rx_q[1][i] : -1, exp_q[1][i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p, pa, quiet;
    clear(0);
    push(0, 8'($urandom_range(0, 255)), 4, p);
    push(0, 8'($urandom_range(0, 255)), 4, pa);
    push(0, 8'($urandom_range(0, 255)), 4, pa);
    wait_edge(p + 1 + 19);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || lvl_a !== 5'd0 || bsy_a !== 1'b0) begin
      errors++; $display("FAIL midreset_state: tx=%b level=%0d busy=%b, expected 1/0/0", tx_a, lvl_a, bsy_a);
    end
    tick(); rst_n = 1'b1;
    clear(0); clear(1);
    quiet = 1;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (tx_a !== 1'b1 || bsy_a !== 1'b0) quiet = 0; end
    tick();
    checks++; if (!quiet) begin errors++; $display("FAIL midreset_quiet: line active after reset with no push"); end
    push(0, 8'($urandom_range(0, 255)), 4, p);
    wait_rx(0, 1, flen(0) + 50);
    checks++;
    if (rx_q[0].size() != 1 || rx_q[0][0] != exp_q[0][0] || !ok_q[0][0]) begin
      errors++; $display("FAIL midreset_resend: got %0d bytes first %h, expected %h", rx_q[0].size(), rx_q[0].size() ? rx_q[0][0] : -1, exp_q[0][0]);
    end
  endtask

  task automatic test_simul_push_pop();
    int p, pa;
    logic [7:0] z;
    clear(0);
    push(0, 8'($urandom_range(0, 255)), 4, p);
    tick(); tick();
    for (int i = 0; i < 5; i++) push(0, 8'($urandom_range(0, 255)), 4, pa);
    wait_edge(p + flen(0));
    @(negedge clk);
    checks++; if (lvl_a !== 5'd5) begin errors++; $display("FAIL simul_pre_level: got %0d, expected 5", lvl_a); end
    z = 8'($urandom_range(0, 255));
    set_in(0, 1'b1, z);
    tick();
    set_in(0, 1'b0, 8'h00);
    exp_q[0].push_back(int'(z));
    @(negedge clk);
    checks++; if (lvl_a !== 5'd5 || bsy_a !== 1'b1 || tx_a !== 1'b0) begin
      errors++; $display("FAIL simul_level: level=%0d busy=%b tx=%b, expected 5/1/0", lvl_a, bsy_a, tx_a);
    end
    tick();
    wait_rx(0, 7, 7 * flen(0) + 100);
    for (int i = 0; i < exp_q[0].size(); i++) begin
      checks++;
      if (i >= rx_q[0].size() || rx_q[0][i] != exp_q[0][i] || !ok_q[0][i]) begin
        errors++; $display("FAIL simul_byte %0d: got %h, expected %h", i, i < rx_q[0].size() ? rx_q[0][i] : -1, exp_q[0][i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0; dat_a = 8'h00; dat_b = 8'h00;
    repeat (3) tick();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_two_stop();
    test_reset_mid();
    test_simul_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
